// File: rtl/axs_wr_fsm.sv
// AXI4 write-channel slave controller for axs_s0: one burst at a time, W beats
// streamed into the input FIFO under in_fifo_full backpressure, one B per burst.
module axs_wr_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  axs_s0_awid,
  input  logic [15:0] axs_s0_awaddr,
  input  logic [7:0]  axs_s0_awlen,
  input  logic [2:0]  axs_s0_awsize,
  input  logic [1:0]  axs_s0_awburst,
  input  logic        axs_s0_awvalid,
  output logic        axs_s0_awready,
  input  logic        axs_s0_wlast,
  input  logic        axs_s0_wvalid,
  output logic        axs_s0_wready,
  output logic [3:0]  axs_s0_bid,
  output logic [1:0]  axs_s0_bresp,
  output logic        axs_s0_bvalid,
  input  logic        axs_s0_bready,
  input  logic        in_fifo_full,
  output logic        in_fifo_push,
  output logic [15:0] wr_addr
);

  localparam logic [7:0] INIT     = 8'h01;
  localparam logic [7:0] AW_READY = 8'h02;
  localparam logic [7:0] W_DATA   = 8'h04;
  localparam logic [7:0] B_RESP   = 8'h08;

  localparam logic [1:0] BURST_INCR = 2'b01;

  logic [7:0]  state;
  logic [3:0]  awid;
  logic [15:0] addr;
  logic [7:0]  remaining;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        err;

  logic        beat_acc;
  logic        final_beat;
  logic [15:0] step;

  assign beat_acc   = axs_s0_wvalid & axs_s0_wready;
  assign final_beat = (remaining == 8'd0);
  assign step       = 16'd1 << awsize;

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    axs_s0_awready = 1'b0;
    axs_s0_wready  = 1'b0;
    axs_s0_bvalid  = 1'b0;
    axs_s0_bresp   = 2'b00;
    case (state)
      AW_READY: axs_s0_awready = 1'b1;
      W_DATA:   axs_s0_wready  = ~in_fifo_full;
      B_RESP: begin
        axs_s0_bvalid = 1'b1;
        axs_s0_bresp  = err ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  assign in_fifo_push = beat_acc;
  assign axs_s0_bid   = awid;
  assign wr_addr      = addr;

  // NOTE: state and registers use non-blocking assignments so every update in
  // this block sees the pre-edge values, matching the flop behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      awid      <= '0;
      addr      <= '0;
      remaining <= '0;
      awsize    <= '0;
      awburst   <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          awid      <= '0;
          addr      <= '0;
          remaining <= '0;
          awsize    <= '0;
          awburst   <= '0;
          err       <= 1'b0;
          state     <= AW_READY;
        end
        AW_READY: begin
          if (axs_s0_awvalid) begin
            awid      <= axs_s0_awid;
            addr      <= axs_s0_awaddr;
            remaining <= axs_s0_awlen;
            awsize    <= axs_s0_awsize;
            awburst   <= axs_s0_awburst;
            // WRAP and the reserved encoding are both flagged as slave errors.
            err       <= axs_s0_awburst[1];
            state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (beat_acc) begin
            // The beat counter, not wlast, ends the burst; wlast only feeds err.
            if (final_beat) begin
              err   <= err | ~axs_s0_wlast;
              state <= B_RESP;
            end else begin
              remaining <= remaining - 8'd1;
              err       <= err | axs_s0_wlast;
              if (awburst == BURST_INCR) addr <= addr + step;
            end
          end
        end
        B_RESP: begin
          if (axs_s0_bready) state <= AW_READY;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
